// File: rtl/rsa_pkg.sv
// Shared RSA definitions: default operand width, FSM state encodings and the
// fixed start-to-finish latency of the square-and-always-multiply schedule.
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic {
        MM_IDLE = 1'b0,
        MM_RUN  = 1'b1
    } mm_state_t;

    // One reduction op plus a square and a multiply per exponent bit, each
    // WIDTH+1 cycles, then one DONE cycle.
    function automatic int calc_lat(input int w);
        return (2 * w + 1) * (w + 1) + 1;
    endfunction

    localparam int LAT = calc_lat(DEFAULT_WIDTH);

endpackage

// File: rtl/rsa_encrypt_if.sv
// Request/result bundle between a requester (master) and the RSA engine (slave),
// plus read-only views of both FSM states.
interface rsa_encrypt_if #(
    parameter int WIDTH = rsa_pkg::DEFAULT_WIDTH
);
    import rsa_pkg::*;

    // start is a one-cycle request sampled only while the engine is IDLE; m/e/n
    // are captured on that edge. finish is a one-cycle pulse marking c_encrypted
    // valid, and c_encrypted then holds until the next finish. busy covers the
    // cycle after acceptance through the finish cycle.
    logic             start;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] c_encrypted;
    logic             finish;
    logic             busy;
    state_t           dbg_state;
    mm_state_t        dbg_mm_state;

    modport master (
        output start, m, e, n,
        input  c_encrypted, finish, busy, dbg_state, dbg_mm_state
    );

    modport slave (
        input  start, m, e, n,
        output c_encrypted, finish, busy, dbg_state, dbg_mm_state
    );

endinterface

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved (Blakley) modular multiplier: r = a*b mod n, b < n.
// One load cycle, then WIDTH iterate cycles consuming a MSB first.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             op_done,
    output logic [WIDTH-1:0] r,
    output mm_state_t        dbg_state
);

    localparam int RW = WIDTH + 2;
    localparam int IW = $clog2(WIDTH);

    mm_state_t        r_state;
    mm_state_t        w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [RW-1:0]    r_acc;
    logic [IW-1:0]    r_cnt;

    logic [RW-1:0]    w_n_ext;
    logic             w_sub_en;
    logic [RW-1:0]    w_add;
    logic [RW-1:0]    w_s1;
    logic [RW-1:0]    w_s2;

    // 2r + a_i*b stays below 3n, so two conditional subtracts fully reduce it.
    // With n == 0 the subtracts are off and the value just wraps harmlessly.
    always_comb begin
        w_n_ext  = {2'b00, r_n};
        w_sub_en = (r_n != '0);
        w_add    = (r_acc << 1) + (r_a[WIDTH-1] ? {2'b00, r_b} : {RW{1'b0}});
        w_s1     = (w_sub_en && (w_add >= w_n_ext)) ? (w_add - w_n_ext) : w_add;
        w_s2     = (w_sub_en && (w_s1 >= w_n_ext)) ? (w_s1 - w_n_ext) : w_s1;
    end

    always_comb begin
        w_next  = r_state;
        op_done = 1'b0;
        case (r_state)
            MM_IDLE: if (op_start) w_next = MM_RUN;
            MM_RUN: begin
                if (r_cnt == '0) begin
                    op_done = 1'b1;
                    w_next  = MM_IDLE;
                end
            end
            default: w_next = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MM_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_n     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == MM_IDLE && op_start) begin
                r_a   <= a;
                r_b   <= b;
                r_n   <= n;
                r_acc <= '0;
                r_cnt <= IW'(WIDTH - 1);
            end else if (r_state == MM_RUN) begin
                r_a   <= r_a << 1;
                r_acc <= w_s2;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign r         = w_s2[WIDTH-1:0];
    assign dbg_state = r_state;

endmodule

// File: rtl/rsa_encrypt.sv
// RSA public-key operation c = m^e mod n with a fixed square-and-always-multiply
// schedule, so latency is independent of m, e and n.
module rsa_encrypt
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic          clk,
    input logic          rst,
    rsa_encrypt_if.slave bus
);

    localparam int IW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_c;
    logic [IW-1:0]    r_bit;
    logic             r_finish;
    logic             r_busy;
    logic             r_op_run;

    logic             w_op_start;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_op_done;
    logic [WIDTH-1:0] w_r;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk       (clk),
        .rst       (rst),
        .op_start  (w_op_start),
        .a         (w_a),
        .b         (w_b),
        .n         (r_n),
        .op_done   (w_op_done),
        .r         (w_r),
        .dbg_state (bus.dbg_mm_state)
    );

    // Each compute state issues exactly one modmul; op_start fires on its first cycle.
    always_comb begin
        w_next     = r_state;
        w_op_start = 1'b0;
        w_a        = '0;
        w_b        = '0;
        case (r_state)
            IDLE: if (bus.start) w_next = PRE;
            PRE: begin
                w_op_start = !r_op_run;
                w_a        = r_m;
                w_b        = WIDTH'(1);
                if (w_op_done) w_next = SQR;
            end
            SQR: begin
                w_op_start = !r_op_run;
                w_a        = r_acc;
                w_b        = r_acc;
                if (w_op_done) w_next = MUL;
            end
            MUL: begin
                w_op_start = !r_op_run;
                w_a        = r_acc;
                w_b        = r_base;
                if (w_op_done) w_next = (r_bit == '0) ? DONE : SQR;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_m      <= '0;
            r_e      <= '0;
            r_n      <= '0;
            r_base   <= '0;
            r_acc    <= '0;
            r_c      <= '0;
            r_bit    <= '0;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
            r_op_run <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_finish <= 1'b0;
            if (w_op_start)     r_op_run <= 1'b1;
            else if (w_op_done) r_op_run <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_m    <= bus.m;
                        r_e    <= bus.e;
                        r_n    <= bus.n;
                        r_bit  <= IW'(WIDTH - 1);
                        r_busy <= 1'b1;
                    end else if (r_finish) begin
                        r_busy <= 1'b0;
                    end
                end
                PRE: begin
                    if (w_op_done) begin
                        r_base <= w_r;
                        r_acc  <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end
                end
                SQR: if (w_op_done) r_acc <= w_r;
                MUL: begin
                    // The product is always computed; the exponent bit only selects it.
                    if (w_op_done) begin
                        r_acc <= r_e[r_bit] ? w_r : r_acc;
                        r_bit <= r_bit - 1'b1;
                    end
                end
                DONE: begin
                    r_c      <= (r_n == '0) ? '0 : r_acc;
                    r_finish <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.c_encrypted = r_c;
    assign bus.finish      = r_finish;
    assign bus.busy        = r_busy;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_rsa_encrypt.sv
// Self-checking bench for rsa_encrypt: vector table, random operands against a
// modular-exponentiation model, reset abort and start-while-busy sequences.
module tb_rsa_encrypt;
    import rsa_pkg::*;

    localparam int W       = 16;
    localparam int LAT_EXP = 562;
    localparam int LIMIT   = 800;

    typedef struct {
        string        name;
        logic [W-1:0] m;
        logic [W-1:0] e;
        logic [W-1:0] n;
        logic [W-1:0] c;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [W-1:0] exp_q[$];
    vec_t vecs[10];

    rsa_encrypt_if #(.WIDTH(W)) bus ();

    rsa_encrypt #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // reference: right-to-left binary exponentiation with wide integers
    function automatic logic [W-1:0] model_pow(input logic [W-1:0] m,
                                               input logic [W-1:0] e,
                                               input logic [W-1:0] n);
        longint unsigned res;
        longint unsigned base;
        longint unsigned nn;
        if (n == '0) return '0;
        nn   = longint'(n);
        res  = 1 % nn;
        base = longint'(m) % nn;
        for (int i = 0; i < W; i++) begin
            if (e[i]) res = (res * base) % nn;
            base = (base * base) % nn;
        end
        return res[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.m     = m;
        bus.e     = e;
        bus.n     = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.m     = '0;
        bus.e     = '0;
        bus.n     = '0;
    endtask

    // scoreboard: waits for finish, compares against the head of exp_q
    task automatic wait_done(input string name, input int lat0);
        int lat;
        int busy_low;
        bit seen;
        logic [W-1:0] exp;
        lat      = lat0;
        busy_low = 0;
        seen     = 1'b0;
        while (!seen && lat < LIMIT) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.finish) seen = 1'b1;
            else if (!bus.busy) busy_low++;
        end
        check({name, " finish_seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(LAT_EXP));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({name, " result"}, 32'(bus.c_encrypted), 32'(exp));
        check({name, " busy_gaps"}, 32'(busy_low), 32'd0);
        check({name, " busy_at_finish"}, 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check({name, " finish_pulse"}, 32'(bus.finish), 32'd0);
        check({name, " busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic count_finishes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.finish) cnt++;
        end
    endtask

    initial begin
        int lat;
        int fin_cnt;
        logic [W-1:0] rm, re, rn;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.m     = '0;
        bus.e     = '0;
        bus.n     = '0;

        vecs[0] = '{"textbook",  16'd89,    16'd3,      16'd3127,  16'd1394};
        vecs[1] = '{"m_ge_n",    16'd3216,  16'd3,      16'd3127,  16'd1394};
        vecs[2] = '{"e_one",     16'd2,     16'd1,      16'd3127,  16'd2};
        vecs[3] = '{"e_ffff",    16'd2,     16'hFFFF,   16'd3127,  model_pow(16'd2, 16'hFFFF, 16'd3127)};
        vecs[4] = '{"e_zero",    16'd1234,  16'd0,      16'd3127,  16'd1};
        vecs[5] = '{"n_one",     16'd5,     16'd7,      16'd1,     16'd0};
        vecs[6] = '{"n_zero",    16'd7,     16'd5,      16'd0,     16'd0};
        vecs[7] = '{"n_even",    16'd3,     16'd5,      16'd100,   16'd43};
        vecs[8] = '{"n_max",     16'd65534, 16'd3,      16'd65535, 16'd65534};
        vecs[9] = '{"m_zero",    16'd0,     16'd5,      16'd3127,  16'd0};

        repeat (3) @(posedge clk);
        #1;
        check("reset c_encrypted", 32'(bus.c_encrypted), 32'd0);
        check("reset finish", 32'(bus.finish), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vecs[i].c);
            start_op(vecs[i].m, vecs[i].e, vecs[i].n);
            wait_done(vecs[i].name, 0);
        end

        for (int i = 0; i < 16; i++) begin
            rm = W'($urandom_range(0, 65535));
            re = W'($urandom_range(0, 65535));
            rn = (i < 2) ? W'($urandom_range(1, 3)) : W'($urandom_range(2, 65535));
            exp_q.push_back(model_pow(rm, re, rn));
            start_op(rm, re, rn);
            wait_done("random", 0);
        end

        // second start while busy must be ignored
        exp_q.push_back(16'd1394);
        start_op(16'd89, 16'd3, 16'd3127);
        lat = 0;
        repeat (10) begin
            @(posedge clk);
            lat++;
        end
        #1;
        bus.start = 1'b1;
        bus.m     = 16'd5;
        bus.e     = 16'd3;
        bus.n     = 16'd100;
        @(posedge clk);
        lat++;
        #1;
        bus.start = 1'b0;
        bus.m     = '0;
        bus.e     = '0;
        bus.n     = '0;
        wait_done("busy_start", lat);
        count_finishes(600, fin_cnt);
        check("busy_start extra finish", 32'(fin_cnt), 32'd0);

        // reset mid-operation aborts without a finish pulse
        start_op(16'd2, 16'd5, 16'd3127);
        repeat (199) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst c_encrypted", 32'(bus.c_encrypted), 32'd0);
        check("midrst finish", 32'(bus.finish), 32'd0);
        check("midrst state", 32'(bus.dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        count_finishes(600, fin_cnt);
        check("midrst no finish", 32'(fin_cnt), 32'd0);
        exp_q.push_back(16'd1394);
        start_op(16'd89, 16'd3, 16'd3127);
        wait_done("after_reset", 0);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
